// File: rtl/reg_slice.sv
// -----------------------------------------------------------------------------
// reg_slice
// Two-entry valid/ready register slice (main + skid register). Every handshake
// output comes straight from a flop, so the slice breaks timing on both the
// forward (valid/data) and the backward (ready) paths.
//
// Optional feature: define REG_SLICE_PERF_EN to add the xfer_cnt output, a
// 32-bit wrapping count of downstream transfers.
//
// Ports
//   clk       in   clock, all state changes on its rising edge
//   rst_n     in   asynchronous active-low reset
//   flush     in   synchronous clear of all held entries
//   s_valid   in   upstream payload valid
//   s_data    in   upstream payload [BITWIDTH]
//   s_ready   out  slice can accept (flop)
//   m_valid   out  downstream payload valid (flop)
//   m_data    out  downstream payload [BITWIDTH] (flop, the main register)
//   m_ready   in   downstream can accept
//   occ       out  number of held entries, 0..2 (flop)
//   xfer_cnt  out  downstream transfer count [32] (REG_SLICE_PERF_EN only)
// -----------------------------------------------------------------------------
module reg_slice #(
    parameter int unsigned BITWIDTH = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                s_valid,
    input  logic [BITWIDTH-1:0] s_data,
    output logic                s_ready,
    output logic                m_valid,
    output logic [BITWIDTH-1:0] m_data,
    input  logic                m_ready,
    output logic [1:0]          occ
`ifdef REG_SLICE_PERF_EN
    ,
    output logic [31:0]         xfer_cnt
`endif
);

    localparam int unsigned OCC_W = 2;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t                state_q;
    state_t                state_d;
    logic [BITWIDTH-1:0]   skid_q;
    logic [BITWIDTH-1:0]   skid_d;
    logic [BITWIDTH-1:0]   main_d;
    logic                  s_ready_d;
    logic                  m_valid_d;
    logic [OCC_W-1:0]      occ_d;
    logic                  s_fire;
    logic                  m_fire;

    // Handshake events, evaluated from the registered valid/ready flops.
    assign s_fire = s_valid & s_ready;
    assign m_fire = m_valid & m_ready;

    // State, payload and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            m_data  <= '0;
            skid_q  <= '0;
            s_ready <= 1'b1;
            m_valid <= 1'b0;
            occ     <= '0;
        end else begin
            state_q <= state_d;
            m_data  <= main_d;
            skid_q  <= skid_d;
            s_ready <= s_ready_d;
            m_valid <= m_valid_d;
            occ     <= occ_d;
        end
    end

    // Next state, register loads, and next-cycle handshake outputs.
    always_comb begin
        state_d   = state_q;
        main_d    = m_data;
        skid_d    = skid_q;
        s_ready_d = 1'b1;
        m_valid_d = 1'b0;
        occ_d     = '0;

        unique case (state_q)
            ST_EMPTY: begin
                if (s_fire) begin
                    main_d  = s_data;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (s_fire && m_fire) begin
                    // Pass-through: new word replaces the one leaving.
                    main_d = s_data;
                end else if (s_fire) begin
                    skid_d  = s_data;
                    state_d = ST_TWO;
                end else if (m_fire) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_TWO: begin
                // s_ready is low here, so only the downstream side can move.
                if (m_fire) begin
                    main_d  = skid_q;
                    state_d = ST_ONE;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase

        // Flush wins over every fire event; accepted words are dropped and
        // the data registers are left as they were.
        if (flush) begin
            state_d = ST_EMPTY;
            main_d  = m_data;
            skid_d  = skid_q;
        end

        // Outputs are a pure function of the state being entered.
        unique case (state_d)
            ST_EMPTY: begin
                s_ready_d = 1'b1;
                m_valid_d = 1'b0;
                occ_d     = OCC_W'(0);
            end
            ST_ONE: begin
                s_ready_d = 1'b1;
                m_valid_d = 1'b1;
                occ_d     = OCC_W'(1);
            end
            ST_TWO: begin
                s_ready_d = 1'b0;
                m_valid_d = 1'b1;
                occ_d     = OCC_W'(2);
            end
            default: begin
                s_ready_d = 1'b1;
                m_valid_d = 1'b0;
                occ_d     = OCC_W'(0);
            end
        endcase
    end

`ifdef REG_SLICE_PERF_EN
    localparam int unsigned CNT_W = 32;

    // Downstream transfer counter; wraps naturally at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_cnt <= '0;
        end else if (flush) begin
            xfer_cnt <= '0;
        end else if (m_fire) begin
            xfer_cnt <= xfer_cnt + CNT_W'(1);
        end
    end
`endif

`ifndef SYNTHESIS
    // Flag outputs must always agree with the occupancy count.
    a_valid_occ: assert property (@(posedge clk) disable iff (!rst_n)
        m_valid == (occ != 2'd0));
    a_ready_occ: assert property (@(posedge clk) disable iff (!rst_n)
        s_ready == (occ != 2'd2));
    // A stalled word must not change underneath the consumer.
    a_stall_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (m_valid && !m_ready && !flush) |=> (m_valid && $stable(m_data)));
`endif

endmodule

// File: tb/tb_reg_slice.sv
// -----------------------------------------------------------------------------
// tb_reg_slice
// Bench for reg_slice. A queue-based model holds the words the slice should
// contain; a compare process checks the DUT against it every falling edge,
// and directed scenarios add literal expectations on top.
// -----------------------------------------------------------------------------
module tb_reg_slice;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         flush;
    logic         s_valid;
    logic [W-1:0] s_data;
    logic         s_ready;
    logic         m_valid;
    logic [W-1:0] m_data;
    logic         m_ready;
    logic [1:0]   occ;
`ifdef REG_SLICE_PERF_EN
    logic [31:0]  xfer_cnt;
`endif

    int checks = 0;
    int errors = 0;

    logic [W-1:0] mq[$];       // words the slice should be holding, oldest first
    logic [W-1:0] dut_out[$];  // words observed leaving the DUT
    int           sr_low = 0;
    bit           stream_mon = 1'b0;

    reg_slice #(.BITWIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (flush),
        .s_valid (s_valid),
        .s_data  (s_data),
        .s_ready (s_ready),
        .m_valid (m_valid),
        .m_data  (m_data),
        .m_ready (m_ready),
        .occ     (occ)
`ifdef REG_SLICE_PERF_EN
        ,
        .xfer_cnt(xfer_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a FIFO of at most two words; flush and reset empty it.
    always @(posedge clk or negedge rst_n) begin
        bit sf;
        bit mf;
        if (!rst_n) begin
            mq.delete();
        end else begin
            sf = s_valid && (mq.size() < 2);
            mf = m_ready && (mq.size() > 0);
            if (m_valid && m_ready) dut_out.push_back(m_data);
            if (stream_mon && !s_ready) sr_low++;
            if (flush) begin
                mq.delete();
            end else begin
                if (mf) void'(mq.pop_front());
                if (sf) mq.push_back(s_data);
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            check("m_valid", 64'(m_valid), 64'(mq.size() > 0));
            check("s_ready", 64'(s_ready), 64'(mq.size() < 2));
            check("occ", 64'(occ), 64'(mq.size()));
            if (mq.size() > 0) check("m_data", 64'(m_data), 64'(mq[0]));
        end
    end

    // Offer one word and hold it until accepted (bounded).
    task automatic send(input logic [W-1:0] d);
        bit acc;
        acc = 1'b0;
        s_valid = 1'b1;
        s_data  = d;
        for (int i = 0; i < 50 && !acc; i++) begin
            @(posedge clk);
            acc = s_ready;
            @(negedge clk);
        end
        s_valid = 1'b0;
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: word 0x%0h not accepted, got s_ready=0 expected 1", d);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        flush   = 1'b0;
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Reset values
        check("rst_m_valid", 64'(m_valid), 64'd0);
        check("rst_s_ready", 64'(s_ready), 64'd1);
        check("rst_occ", 64'(occ), 64'd0);
        check("rst_m_data", 64'(m_data), 64'd0);

        // Single word, 1-cycle latency
        m_ready = 1'b1;
        dut_out.delete();
        send(32'hA5A5_A5A5);
        check("single_valid", 64'(m_valid), 64'd1);
        check("single_data", 64'(m_data), 64'hA5A5_A5A5);
        @(negedge clk);
        check("single_occ_after", 64'(occ), 64'd0);
        check("single_count", 64'(dut_out.size()), 64'd1);

        // Streaming 1..16 at full rate
        dut_out.delete();
        stream_mon = 1'b1;
        for (int i = 1; i <= 16; i++) send(W'(i));
        repeat (2) @(negedge clk);
        stream_mon = 1'b0;
        check("stream_count", 64'(dut_out.size()), 64'd16);
        for (int i = 0; i < 16 && i < dut_out.size(); i++)
            check("stream_word", 64'(dut_out[i]), 64'(i + 1));
        check("stream_sready_low", 64'(sr_low), 64'd0);

        // Backpressure: 1,2 fill the slice, 3 waits upstream
        m_ready = 1'b0;
        dut_out.delete();
        send(32'd1);
        check("bp_occ1", 64'(occ), 64'd1);
        send(32'd2);
        check("bp_occ2", 64'(occ), 64'd2);
        check("bp_sready", 64'(s_ready), 64'd0);
        fork
            send(32'd3);
            begin
                repeat (3) @(negedge clk);
                check("bp_stall_data", 64'(m_data), 64'd1);
                check("bp_stall_occ", 64'(occ), 64'd2);
                m_ready = 1'b1;
            end
        join
        repeat (3) @(negedge clk);
        check("bp_count", 64'(dut_out.size()), 64'd3);
        for (int i = 0; i < 3 && i < dut_out.size(); i++)
            check("bp_word", 64'(dut_out[i]), 64'(i + 1));

        // Flush while full, no upstream traffic
        m_ready = 1'b0;
        send(32'h11);
        send(32'h22);
        check("fl_occ_pre", 64'(occ), 64'd2);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("fl_m_valid", 64'(m_valid), 64'd0);
        check("fl_s_ready", 64'(s_ready), 64'd1);
        check("fl_occ", 64'(occ), 64'd0);
        dut_out.delete();
        m_ready = 1'b1;
        send(32'h55);
        repeat (3) @(negedge clk);
        check("fl_after_count", 64'(dut_out.size()), 64'd1);
        if (dut_out.size() > 0) check("fl_after_word", 64'(dut_out[0]), 64'h55);

        // Flush beats a simultaneous accept
        m_ready = 1'b0;
        send(32'h66);
        s_valid = 1'b1;
        s_data  = 32'h77;
        flush   = 1'b1;
        @(negedge clk);
        flush   = 1'b0;
        s_valid = 1'b0;
        check("fl_sfire_occ", 64'(occ), 64'd0);

        // Asynchronous reset while stalled and full
        send(32'hA1);
        send(32'hA2);
        check("ar_occ_pre", 64'(occ), 64'd2);
        #2 rst_n = 1'b0;
        #1;
        check("ar_m_valid", 64'(m_valid), 64'd0);
        check("ar_occ", 64'(occ), 64'd0);
        check("ar_s_ready", 64'(s_ready), 64'd1);
        check("ar_m_data", 64'(m_data), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dut_out.delete();
        m_ready = 1'b1;
        send(32'hB1);
        repeat (3) @(negedge clk);
        check("ar_after_count", 64'(dut_out.size()), 64'd1);
        if (dut_out.size() > 0) check("ar_after_word", 64'(dut_out[0]), 64'hB1);

        // Mixed traffic pattern, checked cycle by cycle against the model
        for (int i = 0; i < 40; i++) begin
            s_valid = (i % 3) != 2;
            m_ready = (i % 4) != 0 && (i % 7) != 3;
            flush   = (i == 23);
            s_data  = 32'h1000 + W'(i);
            @(negedge clk);
        end
        s_valid = 1'b0;
        flush   = 1'b0;
        m_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("mix_drained", 64'(occ), 64'd0);

`ifdef REG_SLICE_PERF_EN
        // Transfer counter wrap and flush clear
        m_ready = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("cnt_flush0", 64'(xfer_cnt), 64'd0);
        force dut.xfer_cnt = 32'hFFFF_FFFE;
        #1 release dut.xfer_cnt;
        check("cnt_preload", 64'(xfer_cnt), 64'hFFFF_FFFE);
        m_ready = 1'b1;
        send(32'hC1);
        send(32'hC2);
        repeat (2) @(negedge clk);
        check("cnt_wrap", 64'(xfer_cnt), 64'd0);
        send(32'hC3);
        repeat (2) @(negedge clk);
        check("cnt_one", 64'(xfer_cnt), 64'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("cnt_flush", 64'(xfer_cnt), 64'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_slice.md
REG_SLICE -- requirements
Module: reg_slice

Interface
REQ-001 SHALL have parameter BITWIDTH, default 32, payload width in bits (>=1).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port flush  input  1  synchronous clear of all held entries.
REQ-005 SHALL have port s_valid  input  1  upstream payload valid.
REQ-006 SHALL have port s_data  input  BITWIDTH  upstream payload.
REQ-007 SHALL have port s_ready  output  1  slice can accept; driven directly from a flop.
REQ-008 SHALL have port m_valid  output  1  downstream payload valid; driven directly from a flop.
REQ-009 SHALL have port m_data  output  BITWIDTH  downstream payload; driven directly from a flop.
REQ-010 SHALL have port m_ready  input  1  downstream can accept.
REQ-011 SHALL have port occ  output  2  held-entry count (0, 1 or 2).

Function
REQ-012 SHALL define s_fire = s_valid & s_ready and m_fire = m_valid & m_ready.
REQ-013 SHALL implement states EMPTY (occ=0), ONE (main reg valid, occ=1) and TWO (main + skid reg valid, occ=2).
REQ-014 SHALL drive m_valid=1 in ONE and TWO, s_ready=1 in EMPTY and ONE, s_ready=0 in TWO.
REQ-015 EMPTY: on s_fire, SHALL load main<=s_data and go to ONE.
REQ-016 ONE: s_fire & m_fire SHALL load main<=s_data and stay in ONE; s_fire only SHALL load skid<=s_data and go to TWO; m_fire only SHALL go to EMPTY.
REQ-017 TWO: on m_fire, SHALL move main<=skid and go to ONE; with no m_fire, SHALL hold.
REQ-018 SHALL present the first word on m_data exactly 1 cycle after its s_fire (1-cycle latency).
REQ-019 SHALL sustain one transfer per cycle when m_ready stays high.
REQ-020 SHALL keep m_data and m_valid stable while m_valid=1 and m_ready=0.
REQ-021 SHALL preserve FIFO order; no word is dropped or duplicated except by flush.
REQ-022 flush=1 SHALL force EMPTY next cycle with priority over all fire events; a word accepted on s_fire in the flush cycle SHALL be discarded.
REQ-023 SHALL leave data registers unchanged when no load occurs.

Reset
REQ-024 On rst_n=0, SHALL go immediately (asynchronously) to EMPTY: m_valid=0, s_ready=1, occ=0, m_data=0, skid=0.
REQ-025 Reset asserted mid-transfer SHALL discard all held words; after deassertion, first s_fire SHALL behave as from EMPTY.

Configuration
REQ-026 With macro REG_SLICE_PERF_EN defined, SHALL add output xfer_cnt (32 bits) counting m_fire events, wrapping 0xFFFFFFFF->0, reset to 0 by rst_n and cleared to 0 by flush.
REQ-027 Without REG_SLICE_PERF_EN, port xfer_cnt and its counter SHALL be absent; all other behaviour identical.

Verification
REQ-028 Reset then single word: s_valid=1, s_data=0xA5A5A5A5 one cycle, m_ready=1 -> m_valid=1, m_data=0xA5A5A5A5 next cycle, occ returns to 0 the cycle after.
REQ-029 Streaming: words 1..16 back-to-back, m_ready=1 -> 16 consecutive m_valid cycles, data 1..16 in order, s_ready never 0.
REQ-030 Backpressure: m_ready=0, send 1,2,3 -> occ 1 then 2, s_ready=0 after second accept, word 3 held upstream; release m_ready -> output 1,2,3 in order, m_data stable while stalled.
REQ-031 Flush in TWO with s_valid=0: occ=2, flush=1 -> next cycle m_valid=0, s_ready=1, occ=0; subsequent word 0x55 emerges alone.
REQ-032 Async reset mid-stall: occ=2, drop rst_n between clock edges -> m_valid=0, occ=0 immediately without a clock edge; no stale word after release.
REQ-033 With REG_SLICE_PERF_EN: preload counter to 0xFFFFFFFE via force, two m_fire -> xfer_cnt=0; flush -> xfer_cnt=0.
